spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter ADDR_W, default 5: register address width in bits; legal range 1..6.
REQ-002 Parameter DATA_W, default 8: register data width in bits; legal range 8..16.
REQ-003 Parameter NUM_REGS, default 25: number of implemented registers; legal range 1..2**ADDR_W.
REQ-004 Port clk_i, input, 1 bit: system clock; the only clock, with a rate of at least 8x the sclk_i rate.
REQ-005 Port rst_ni, input, 1 bit: reset; asynchronous and active-low.
REQ-006 Port sclk_i, input, 1 bit: SPI clock, asynchronous to clk_i; SPI mode 0.
REQ-007 Port cs_i, input, 1 bit: SPI chip select, active-low, asynchronous.
REQ-008 Port mosi_i, input, 1 bit: SPI data in, MSB first.
REQ-009 Port miso_o, output, 1 bit: SPI data out, MSB first.
REQ-010 Port regs_o, output, NUM_REGS*DATA_W bits: flattened register file; register k occupies bits [k*DATA_W +: DATA_W].
REQ-011 Port wr_stb_o, output, NUM_REGS bits: bit k pulses for one clk_i cycle when register k is written.
REQ-012 Port busy_o, output, 1 bit: high while a transaction is active (synchronised cs_i low).

Function
REQ-013 sclk_i, cs_i and mosi_i SHALL each pass through a 2-flop synchroniser; sclk_i edges are detected from the synchronised value, so input-to-action latency is 3 clk_i cycles.
REQ-014 The FSM SHALL have three states: IDLE, CMD and DATA.
  - IDLE -> CMD on synchronised cs falling.
  - CMD -> DATA after 8 command bits.
  - Any state -> IDLE on synchronised cs rising.
REQ-015 The command byte layout SHALL be: bit7 = write (1) / read (0); bit6 = auto-increment; bits[ADDR_W-1:0] = start address. Bits between bit5 and ADDR_W are ignored.
REQ-016 mosi SHALL be sampled on sclk rising edges; miso_o SHALL change only on sclk falling edges, except at the DATA entry load (REQ-020).
REQ-017 In DATA state, each DATA_W received bits SHALL form one word; on the last bit of a write word, the addressed register updates and its wr_stb_o bit pulses in the same clk_i cycle.
REQ-018 After each word, the address SHALL increment if auto-increment is set, wrapping NUM_REGS-1 -> 0; otherwise it stays fixed (repeated access to one register).
REQ-019 Writes to address >= NUM_REGS SHALL be discarded with no strobe; reads from such addresses SHALL return 0.
REQ-020 On a read, the addressed register SHALL load into the transmit shifter at DATA entry and on every word boundary, and its MSB SHALL appear on miso_o before the first sclk rising edge of that word.
REQ-021 miso_o SHALL be 0 whenever not in a read DATA phase.
REQ-022 If cs rises mid-word (command or data), the partial word SHALL be discarded: no write, no strobe. Completed earlier words in the burst stay committed.
REQ-023 A cs rise and the final data bit in the same cycle SHALL commit the word.

Reset
REQ-024 While rst_ni is low:
  - FSM -> IDLE;
  - all registers, shifters, counters and synchronisers clear (synchroniser cs flops reset to 1);
  - regs_o = 0, wr_stb_o = 0, miso_o = 0, busy_o = 0.
REQ-025 Reset asserted mid-transaction SHALL abort it. After release, the block waits for a fresh cs falling edge; cs already low at release SHALL NOT start a transaction.

Structure
REQ-026 Package tt6581_pkg SHALL hold:
  - the FSM state enum;
  - command bit positions CMD_WR_BIT = 7 and CMD_AI_BIT = 6;
  - command length CMD_LEN = 8.
REQ-027 The 2-flop synchroniser SHALL be one sub-module, sync_2ff, instantiated three times.

Verification
REQ-028 Write 0x80|0x04, then 0xA5 -> regs_o reg4 = 0xA5; wr_stb_o[4] pulses exactly once; no other register changes.
REQ-029 Burst write 0xC0|0x17, then 0x11, 0x22, 0x33 -> reg23 = 0x11, reg24 = 0x22, reg0 = 0x33 (wrap); three strobes.
REQ-030 Preload reg2 = 0x5A; read 0x42 with 16 data clocks -> miso_o returns 0x5A, then reg3's value.
REQ-031 Write to 0x1E (>= NUM_REGS) -> no strobe and no register change; a read of 0x1E returns 0x00.
REQ-032 cs raised after 5 bits of a data word -> target register unchanged and no strobe; the next transaction behaves normally.
REQ-033 rst_ni pulsed low mid-burst -> all outputs 0 within the same cycle; the next transaction succeeds only after a new cs falling edge.

Source files
------------

// File: rtl/tt6581_pkg.sv
// rtl/tt6581_pkg.sv - shared FSM state type and command byte layout for spi_reg_bridge
package tt6581_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int CMD_WR_BIT = 7;
    localparam int CMD_AI_BIT = 6;
    localparam int CMD_LEN    = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with selectable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 slave giving burst read/write access to a flat register file
module spi_reg_bridge
    import tt6581_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 25
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sclk_i,
    input  logic                         cs_i,
    input  logic                         mosi_i,
    output logic                         miso_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_stb_o,
    output logic                         busy_o
);

    localparam int CNT_W = 5;

    logic                w_sclk_s, w_cs_s, w_mosi_s;
    logic                r_sclk_q, r_cs_q;
    logic [1:0]          r_settle;
    logic                r_armed;
    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_W-2:0]   r_shift;
    logic [DATA_W-1:0]   r_tx;
    logic                r_wr, r_ai, r_reload;
    logic [ADDR_W-1:0]   r_addr;
    logic [NUM_REGS-1:0] r_wr_stb;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_sclk (.i_clk(clk_i), .i_rst_n(rst_ni), .i_d(sclk_i), .o_q(w_sclk_s));
    sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs   (.i_clk(clk_i), .i_rst_n(rst_ni), .i_d(cs_i),   .o_q(w_cs_s));
    sync_2ff #(.RESET_VAL(1'b0)) u_sync_mosi (.i_clk(clk_i), .i_rst_n(rst_ni), .i_d(mosi_i), .o_q(w_mosi_s));

    logic                w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic                w_cmd_last, w_word_last, w_addr_ok;
    logic [DATA_W-1:0]   w_rx_word;
    logic [ADDR_W-1:0]   w_addr_nxt;

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} < (ADDR_W+1)'(NUM_REGS)) return r_regs[a];
        return '0;
    endfunction

    // A cs fall only counts once cs has been seen high after reset, so a
    // bus left selected across reset cannot start a transaction.
    assign w_sclk_rise = w_sclk_s & ~r_sclk_q;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_q;
    assign w_cs_fall   = r_armed & r_cs_q & ~w_cs_s;
    assign w_cs_rise   = ~r_cs_q & w_cs_s;
    assign w_rx_word   = {r_shift, w_mosi_s};
    assign w_cmd_last  = (r_state == ST_CMD) && w_sclk_rise && (r_bit_cnt == CNT_W'(CMD_LEN - 1));
    assign w_word_last = (r_state == ST_DATA) && w_sclk_rise && (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_addr_ok   = ({1'b0, r_addr} < (ADDR_W+1)'(NUM_REGS));
    assign w_addr_nxt  = (r_addr == ADDR_W'(NUM_REGS - 1)) ? '0 : r_addr + ADDR_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
            ST_CMD: begin
                if (w_cs_rise)       w_state_nxt = ST_IDLE;
                else if (w_cmd_last) w_state_nxt = ST_DATA;
            end
            ST_DATA: if (w_cs_rise) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sclk_q  <= 1'b0;
            r_cs_q    <= 1'b1;
            r_settle  <= '0;
            r_armed   <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_wr      <= 1'b0;
            r_ai      <= 1'b0;
            r_reload  <= 1'b0;
            r_addr    <= '0;
            r_wr_stb  <= '0;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else begin
            r_sclk_q <= w_sclk_s;
            r_cs_q   <= w_cs_s;
            r_wr_stb <= '0;
            if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
            else if (w_cs_s)      r_armed  <= 1'b1;

            unique case (r_state)
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        r_shift <= w_rx_word[DATA_W-2:0];
                        if (w_cmd_last) begin
                            r_bit_cnt <= '0;
                            r_wr      <= w_rx_word[CMD_WR_BIT];
                            r_ai      <= w_rx_word[CMD_AI_BIT];
                            r_addr    <= w_rx_word[ADDR_W-1:0];
                            r_tx      <= rd_word(w_rx_word[ADDR_W-1:0]);
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sclk_rise) begin
                        r_shift <= w_rx_word[DATA_W-2:0];
                        if (w_word_last) begin
                            r_bit_cnt <= '0;
                            r_reload  <= 1'b1;
                            if (r_ai) r_addr <= w_addr_nxt;
                            if (r_wr && w_addr_ok) begin
                                r_regs[r_addr]   <= w_rx_word;
                                r_wr_stb[r_addr] <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else if (w_sclk_fall) begin
                        // Next word is fetched on the fall after a boundary so miso only moves on falls.
                        if (r_reload) begin
                            r_tx     <= rd_word(r_addr);
                            r_reload <= 1'b0;
                        end else if (r_bit_cnt != '0) begin
                            r_tx <= r_tx << 1;
                        end
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_reload  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs_o[k*DATA_W +: DATA_W] = r_regs[k];
    end

    assign wr_stb_o = r_wr_stb;
    assign busy_o   = (r_state != ST_IDLE);
    assign miso_o   = (r_state == ST_DATA) && !r_wr && r_tx[DATA_W-1];

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - randomized self-checking bench for spi_reg_bridge against a register-file model
module tb_spi_reg_bridge;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 25;
    localparam int HALF     = 50;

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic                       miso, busy;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]        stb;

    spi_reg_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk), .cs_i(cs), .mosi_i(mosi),
        .miso_o(miso), .regs_o(regs), .wr_stb_o(stb), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [7:0] model [NUM_REGS];
    int         stb_cnt [NUM_REGS];
    logic [7:0] wdata [8];
    logic [7:0] rdata [8];

    typedef struct { int addr; logic [7:0] data; } wr_t;
    wr_t exp_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_addr(input int a, input logic ai);
        if (!ai) return a;
        if (a == NUM_REGS - 1) return 0;
        return (a + 1) % (1 << ADDR_W);
    endfunction

    function automatic int total_stb();
        int s = 0;
        for (int k = 0; k < NUM_REGS; k++) s += stb_cnt[k];
        return s;
    endfunction

    task automatic clear_cnt();
        for (int k = 0; k < NUM_REGS; k++) stb_cnt[k] = 0;
    endtask

    // Model: pending writes become visible when the DUT strobes them; regs_o must match every cycle.
    always @(negedge clk) begin
        wr_t w;
        logic [NUM_REGS*DATA_W-1:0] e;
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
            exp_q.delete();
            chk("reset_outputs", {regs, stb, miso, busy}, 256'd0);
        end else begin
            if (stb != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", stb, 256'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk("strobe_onehot", stb, 256'(1) << w.addr);
                    model[w.addr] = w.data;
                    stb_cnt[w.addr]++;
                end
            end
            for (int k = 0; k < NUM_REGS; k++) e[k*8 +: 8] = model[k];
            chk("regs_o", regs, e);
        end
    end

    task automatic bits(input logic [15:0] v, input int n, output logic [15:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            #HALF;
            rx[i] = miso;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic txn(input logic [7:0] cmd, input int nwords, input int last_bits);
        int a;
        logic wr, ai;
        logic [15:0] rx;
        logic [7:0] expv;
        a  = int'(cmd[4:0]);
        wr = cmd[7];
        ai = cmd[6];
        cs = 1'b0;
        #HALF;
        chk("busy_active", busy, 1);
        bits(16'(cmd), 8, rx);
        for (int w = 0; w < nwords; w++) begin
            int nb;
            nb   = (w == nwords - 1) ? last_bits : 8;
            expv = (a < NUM_REGS) ? model[a] : 8'h00;
            if (wr && nb == 8 && a < NUM_REGS) exp_q.push_back('{addr: a, data: wdata[w]});
            bits(16'(wdata[w] >> (8 - nb)), nb, rx);
            if (!wr && nb == 8) begin
                rdata[w] = rx[7:0];
                chk("miso_read", rx[7:0], expv);
            end
            a = next_addr(a, ai);
        end
        #HALF;
        cs = 1'b1;
        #(HALF * 2);
        chk("pending_writes", exp_q.size(), 0);
        chk("idle_busy", busy, 0);
        chk("idle_miso", miso, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx;
        logic [7:0]  c, snap;
        logic [NUM_REGS*DATA_W-1:0] snap_all;
        int nw, lb;

        clear_cnt();
        repeat (5) @(posedge clk);
        #1;
        chk("reset_regs", regs, 256'd0);
        chk("reset_misc", {stb, miso, busy}, 256'd0);
        rst_n = 1'b1;
        #(HALF * 2);

        clear_cnt();
        wdata[0] = 8'hA5;
        txn(8'h84, 1, 8);
        chk("single_reg4", regs[4*8 +: 8], 8'hA5);
        chk("single_stb4", stb_cnt[4], 1);
        chk("single_total", total_stb(), 1);

        clear_cnt();
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
        txn(8'hD7, 3, 8);
        chk("burst_reg23", regs[23*8 +: 8], 8'h11);
        chk("burst_reg24", regs[24*8 +: 8], 8'h22);
        chk("burst_reg0", regs[0 +: 8], 8'h33);
        chk("burst_total", total_stb(), 3);

        wdata[0] = 8'h5A; txn(8'h82, 1, 8);
        wdata[0] = 8'h3C; txn(8'h83, 1, 8);
        wdata[0] = 8'h00; wdata[1] = 8'h00;
        txn(8'h42, 2, 8);
        chk("read_reg2", rdata[0], 8'h5A);
        chk("read_reg3", rdata[1], 8'h3C);

        clear_cnt();
        snap_all = regs;
        wdata[0] = 8'hFF;
        txn(8'h9E, 1, 8);
        chk("oob_no_stb", total_stb(), 0);
        chk("oob_regs", regs, snap_all);
        wdata[0] = 8'h00;
        txn(8'h1E, 1, 8);
        chk("oob_read", rdata[0], 8'h00);

        clear_cnt();
        snap = regs[5*8 +: 8];
        wdata[0] = 8'hC3;
        txn(8'h85, 1, 5);
        chk("partial_reg5", regs[5*8 +: 8], snap);
        chk("partial_no_stb", total_stb(), 0);
        wdata[0] = 8'h69;
        txn(8'h85, 1, 8);
        chk("after_partial_reg5", regs[5*8 +: 8], 8'h69);

        for (int t = 0; t < 40; t++) begin
            c  = 8'($urandom);
            nw = $urandom_range(1, 3);
            lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            for (int w = 0; w < 8; w++) wdata[w] = 8'($urandom);
            txn(c, nw, lb);
        end

        clear_cnt();
        cs = 1'b0;
        #HALF;
        bits(16'h00C3, 8, rx);
        exp_q.push_back('{addr: 3, data: 8'h4D});
        bits(16'h004D, 8, rx);
        bits(16'h0005, 3, rx);
        chk("pre_reset_reg3", regs[3*8 +: 8], 8'h4D);
        rst_n = 1'b0;
        #1;
        chk("midreset_regs", regs, 256'd0);
        chk("midreset_misc", {stb, miso, busy}, 256'd0);
        #(HALF * 4);
        rst_n = 1'b1;
        #(HALF * 2);
        clear_cnt();
        bits(16'h0081, 8, rx);
        chk("held_cs_busy", busy, 0);
        bits(16'h0077, 8, rx);
        #(HALF * 2);
        chk("held_cs_no_stb", total_stb(), 0);
        chk("held_cs_reg1", regs[1*8 +: 8], 8'h00);
        cs = 1'b1;
        #(HALF * 2);
        wdata[0] = 8'h77;
        txn(8'h81, 1, 8);
        chk("post_reset_reg1", regs[1*8 +: 8], 8'h77);
        chk("post_reset_stb", stb_cnt[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
